// File: rtl/camerica_pkg.sv
// Shared types and constants for the camerica frame histogram.
package camerica_pkg;
   localparam int PIX_W       = 12;
   localparam int HISTO_BINS  = 512;
   localparam int HISTO_WORDS = 256;
   localparam int BIN_W       = $clog2(HISTO_BINS);
   localparam int WA_W        = $clog2(HISTO_WORDS);

   typedef enum logic [1:0] {CLEAR, IDLE, ACC, DRAIN} histo_state_t;

   // Bin index is the top BIN_W bits of the pixel.
   function automatic logic [BIN_W-1:0] bin_of(input logic [PIX_W-1:0] pix);
      return pix[PIX_W-1:PIX_W-BIN_W];
   endfunction
endpackage

// File: rtl/camerica_histo_ram.sv
// Two-bank histogram store: accumulation side with independent read/write
// addresses, plus a registered readout port. All reads have 1-cycle latency.
module camerica_histo_ram
   import camerica_pkg::*;
#(
   parameter int WORD_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_rbank,
   input  logic [WA_W-1:0]   a_raddr,
   output logic [WORD_W-1:0] a_rdata,
   input  logic              a_we,
   input  logic              a_wbank,
   input  logic [WA_W-1:0]   a_waddr,
   input  logic [WORD_W-1:0] a_wdata,
   input  logic              b_re,
   input  logic              b_bank,
   input  logic [WA_W-1:0]   b_addr,
   output logic [WORD_W-1:0] b_rdata
);
   logic [WORD_W-1:0] mem [2][HISTO_WORDS];

   always_ff @(posedge clk) begin
      if (a_we) mem[a_wbank][a_waddr] <= a_wdata;
   end

   // Read-before-write: a read colliding with a write returns the old word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         a_rdata <= mem[a_rbank][a_raddr];
         if (b_re) b_rdata <= mem[b_bank][b_addr];
      end
   end
endmodule

// File: rtl/camerica_histo.sv
// Double-buffered 512-bin frame histogram with a 3-stage forwarding RMW pipe
// and a host readout port on the completed bank.
module camerica_histo
   import camerica_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               pix_valid,
   input  logic [PIX_W-1:0]   pix_data,
   input  logic               pix_eof,
   output logic               frame_done,
   output logic [15:0]        frame_count,
   output logic               dropped,
   input  logic [WA_W-1:0]    hm_address,
   input  logic               hm_bus_enable,
   input  logic               hm_rw,
   output logic [2*CNT_W-1:0] hm_read_data,
   output logic               hm_acknowledge
);
   localparam int WORD_W = 2 * CNT_W;

   histo_state_t          state;
   logic                  rd_bank, acc_bank, init_pend, clr_rd, en_lat;
   logic                  take, s2_lane, w_vld_d;
   logic [WA_W-1:0]       clr_addr, s1_addr, s2_addr, w_addr_d;
   logic [BIN_W-1:0]      pix_bin;
   logic [2:1]            vld_pipe;
   logic [2:1][BIN_W-1:0] bin_pipe;
   logic [WORD_W-1:0]     a_rdata, s1_word, s2_word, s2_new, w_data_d, a_wdata;
   logic [CNT_W-1:0]      s2_half;
   logic                  a_we, a_wbank;
   logic [WA_W-1:0]       a_waddr;

   assign pix_bin = bin_of(pix_data);
   assign s1_addr = bin_pipe[1][BIN_W-1:1];
   assign s2_addr = bin_pipe[2][BIN_W-1:1];
   assign s2_lane = bin_pipe[2][0];

   always_comb begin
      take = 1'b0;
      if (pix_valid) begin
         if (state == IDLE)     take = enable;
         else if (state == ACC) take = en_lat;
      end
   end

   // Newest copy of the word wins: S2 result, then the write landing this cycle.
   always_comb begin
      s1_word = a_rdata;
      if (vld_pipe[2] && s2_addr == s1_addr)  s1_word = s2_new;
      else if (w_vld_d && w_addr_d == s1_addr) s1_word = w_data_d;
   end

   always_comb begin
      s2_half = s2_lane ? s2_word[WORD_W-1:CNT_W] : s2_word[CNT_W-1:0];
      if (!(&s2_half)) s2_half = s2_half + CNT_W'(1);
      s2_new = s2_word;
      if (s2_lane) s2_new[WORD_W-1:CNT_W] = s2_half;
      else         s2_new[CNT_W-1:0]      = s2_half;
   end

   assign a_we    = (state == CLEAR) || vld_pipe[2];
   assign a_wbank = (state == CLEAR && clr_rd) ? rd_bank : acc_bank;
   assign a_waddr = (state == CLEAR) ? clr_addr : s2_addr;
   assign a_wdata = (state == CLEAR) ? '0 : s2_new;

   camerica_histo_ram #(.WORD_W(WORD_W)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .a_rbank (acc_bank),
      .a_raddr (pix_bin[BIN_W-1:1]),
      .a_rdata (a_rdata),
      .a_we    (a_we),
      .a_wbank (a_wbank),
      .a_waddr (a_waddr),
      .a_wdata (a_wdata),
      .b_re    (hm_bus_enable && hm_rw),
      .b_bank  (rd_bank),
      .b_addr  (hm_address),
      .b_rdata (hm_read_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= CLEAR;
         rd_bank        <= 1'b0;
         acc_bank       <= 1'b1;
         init_pend      <= 1'b1;
         clr_rd         <= 1'b0;
         clr_addr       <= '0;
         en_lat         <= 1'b0;
         frame_done     <= 1'b0;
         frame_count    <= '0;
         dropped        <= 1'b0;
         hm_acknowledge <= 1'b0;
         vld_pipe       <= '0;
         bin_pipe       <= '0;
         s2_word        <= '0;
         w_vld_d        <= 1'b0;
         w_addr_d       <= '0;
         w_data_d       <= '0;
      end else begin
         frame_done     <= 1'b0;
         hm_acknowledge <= hm_bus_enable;
         vld_pipe       <= {vld_pipe[1], take};
         bin_pipe       <= {bin_pipe[1], pix_bin};
         s2_word        <= s1_word;
         w_vld_d        <= vld_pipe[2];
         w_addr_d       <= s2_addr;
         w_data_d       <= s2_new;
         case (state)
            CLEAR: begin
               if (pix_valid) dropped <= 1'b1;
               clr_addr <= clr_addr + WA_W'(1);
               // After reset the readable bank is wiped too, on a second pass.
               if (clr_addr == WA_W'(HISTO_WORDS - 1)) begin
                  if (init_pend) begin
                     init_pend <= 1'b0;
                     clr_rd    <= 1'b1;
                  end else begin
                     clr_rd <= 1'b0;
                     state  <= IDLE;
                  end
               end
            end
            IDLE: begin
               if (pix_valid) begin
                  en_lat <= enable;
                  state  <= pix_eof ? DRAIN : ACC;
               end
            end
            ACC: begin
               if (pix_valid && pix_eof) state <= DRAIN;
            end
            DRAIN: begin
               if (vld_pipe == '0) begin
                  rd_bank     <= acc_bank;
                  acc_bank    <= rd_bank;
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 16'd1;
                  state       <= CLEAR;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end
endmodule
